// File: rtl/i2c_byte_master_if.sv
// Client-side handshake and open-drain bus signals of the byte-level I2C master.
interface i2c_byte_master_if;
  logic       start;
  logic       send;
  logic       receive;
  logic [7:0] datasend;
  logic       isReady;
  logic       sended;
  logic [7:0] datareceive;
  logic       received;
  logic       scl_o;
  logic       sda_oe;
  logic       sda_i;
  logic       ack_error;

  // Engine side
  modport master (
    input  start, send, receive, datasend, sda_i,
    output isReady, sended, datareceive, received, scl_o, sda_oe, ack_error
  );

  // Client / bus-model side
  modport slave (
    output start, send, receive, datasend, sda_i,
    input  isReady, sended, datareceive, received, scl_o, sda_oe, ack_error
  );
endinterface

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: generates START / repeated START / STOP, writes and
// reads single bytes with ACK/NACK, and parks SCL low between bytes until the
// client asks for the next one (or a timeout ends the transfer).
module i2c_byte_master #(
  parameter int CLK_DIV      = 125,
  parameter int IDLE_TIMEOUT = 64
) (
  input logic             clk,
  input logic             reset,
  i2c_byte_master_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, START_GEN, WR_BIT, WR_ACK, WR_WAIT, RD_BIT, RD_WAIT, RD_ACK, STOP_GEN
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [2:0]         bit_q, bit_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [7:0]         sh_q, sh_d;
  logic               rw_q, rw_d;
  logic               ackbit_q, ackbit_d;
  logic               mack_q, mack_d;
  logic               ready_q, ready_d;
  logic               sended_q, sended_d;
  logic               received_q, received_d;
  logic [7:0]         drx_q, drx_d;
  logic               ack_err_q, ack_err_d;
  logic               scl_q, scl_d;
  logic               sda_oe_q, sda_oe_d;
  logic               tick;

  // Quarter-period strobe; the divider only runs while the engine is busy
  assign tick = (state_q != IDLE) && (div_q == DIV_W'(CLK_DIV - 1));

  // Next-state and registered-output computation for the whole engine
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    to_d       = to_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    ackbit_d   = ackbit_q;
    mack_d     = mack_q;
    ready_d    = ready_q;
    sended_d   = sended_q;
    received_d = received_q;
    drx_d      = drx_q;
    ack_err_d  = ack_err_q;
    scl_d      = scl_q;
    sda_oe_d   = sda_oe_q;

    if (state_q == IDLE) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d      = bus.datasend;
          rw_d      = bus.datasend[0];
          ready_d   = 1'b0;
          ack_err_d = 1'b0;
          qtr_d     = 2'd0;
          state_d   = START_GEN;
        end
      end

      // Release SDA (SCL may be low for a repeated START), raise SCL,
      // pull SDA low while SCL is high, then pull SCL low.
      START_GEN: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          case (qtr_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_d    = 1'b1;
            2'd2: sda_oe_d = 1'b1;
            2'd3: begin
              scl_d   = 1'b0;
              bit_d   = 3'd0;
              state_d = WR_BIT;
            end
          endcase
        end
      end

      WR_BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          case (qtr_q)
            2'd0: sda_oe_d = ~sh_q[7];
            2'd1: scl_d    = 1'b1;
            2'd2: ;
            2'd3: begin
              scl_d = 1'b0;
              sh_d  = {sh_q[6:0], 1'b0};
              bit_d = bit_q + 1'b1;
              if (bit_q == 3'd7) state_d = WR_ACK;
            end
          endcase
        end
      end

      WR_ACK: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          case (qtr_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_d    = 1'b1;
            2'd2: ackbit_d = bus.sda_i;
            2'd3: begin
              scl_d = 1'b0;
              if (ackbit_q) begin
                ack_err_d = 1'b1;
                state_d   = STOP_GEN;
              end else if (rw_q) begin
                // Read address acknowledged: go straight into the first read byte
                bit_d   = 3'd0;
                state_d = RD_BIT;
              end else begin
                sended_d = 1'b1;
                to_d     = '0;
                state_d  = WR_WAIT;
              end
            end
          endcase
        end
      end

      // SCL parked low; send beats receive when both arrive together
      WR_WAIT: begin
        if (bus.send) begin
          sended_d = 1'b0;
          sh_d     = bus.datasend;
          div_d    = '0;
          qtr_d    = 2'd0;
          bit_d    = 3'd0;
          if (bus.start) begin
            rw_d    = bus.datasend[0];
            state_d = START_GEN;
          end else begin
            state_d = WR_BIT;
          end
        end else if (bus.receive) begin
          sended_d = 1'b0;
          div_d    = '0;
          qtr_d    = 2'd0;
          bit_d    = 3'd0;
          state_d  = RD_BIT;
        end else if (tick) begin
          if (to_q == TO_W'(IDLE_TIMEOUT - 1)) begin
            sended_d = 1'b0;
            qtr_d    = 2'd0;
            state_d  = STOP_GEN;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end

      RD_BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          case (qtr_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_d    = 1'b1;
            2'd2: sh_d     = {sh_q[6:0], bus.sda_i};
            2'd3: begin
              scl_d = 1'b0;
              bit_d = bit_q + 1'b1;
              if (bit_q == 3'd7) begin
                drx_d      = sh_q;
                received_d = 1'b1;
                to_d       = '0;
                state_d    = RD_WAIT;
              end
            end
          endcase
        end
      end

      // SCL parked low holding the read byte; only receive or timeout matter here
      RD_WAIT: begin
        if (bus.receive) begin
          received_d = 1'b0;
          mack_d     = 1'b1;
          div_d      = '0;
          qtr_d      = 2'd0;
          state_d    = RD_ACK;
        end else if (tick) begin
          if (to_q == TO_W'(IDLE_TIMEOUT - 1)) begin
            received_d = 1'b0;
            mack_d     = 1'b0;
            qtr_d      = 2'd0;
            state_d    = RD_ACK;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end

      RD_ACK: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          case (qtr_q)
            2'd0: sda_oe_d = mack_q;
            2'd1: scl_d    = 1'b1;
            2'd2: ;
            2'd3: begin
              scl_d = 1'b0;
              bit_d = 3'd0;
              state_d = mack_q ? RD_BIT : STOP_GEN;
            end
          endcase
        end
      end

      // SDA low, SCL high, SDA released while SCL high, one bus-free quarter
      STOP_GEN: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          case (qtr_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: scl_d    = 1'b1;
            2'd2: sda_oe_d = 1'b0;
            2'd3: begin
              ready_d = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset releases the bus immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      to_q       <= '0;
      sh_q       <= 8'h00;
      rw_q       <= 1'b0;
      ackbit_q   <= 1'b0;
      mack_q     <= 1'b0;
      ready_q    <= 1'b1;
      sended_q   <= 1'b0;
      received_q <= 1'b0;
      drx_q      <= 8'h00;
      ack_err_q  <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      to_q       <= to_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ackbit_q   <= ackbit_d;
      mack_q     <= mack_d;
      ready_q    <= ready_d;
      sended_q   <= sended_d;
      received_q <= received_d;
      drx_q      <= drx_d;
      ack_err_q  <= ack_err_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign bus.isReady     = ready_q;
  assign bus.sended      = sended_q;
  assign bus.received    = received_q;
  assign bus.datareceive = drx_q;
  assign bus.ack_error   = ack_err_q;
  assign bus.scl_o       = scl_q;
  assign bus.sda_oe      = sda_oe_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: a client driver, an I2C slave/bus monitor that
// turns the wire activity into START/STOP/byte tokens, and a token scoreboard.
module tb_i2c_byte_master;

  localparam int CLK_DIV = 4;
  localparam int IDLE_TO = 64;
  localparam logic [1:0] K_S = 2'd1;
  localparam logic [1:0] K_P = 2'd2;
  localparam logic [1:0] K_B = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  i2c_byte_master_if bus();

  i2c_byte_master #(.CLK_DIV(CLK_DIV), .IDLE_TIMEOUT(IDLE_TO)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // open-drain bus: master pulls via sda_oe, slave via slv_sda
  logic slv_sda = 1'b1;
  logic scl_line, sda_line;
  assign scl_line  = bus.scl_o;
  assign sda_line  = bus.sda_oe ? 1'b0 : slv_sda;
  assign bus.sda_i = sda_line;

  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];
  logic [7:0]  slv_rd_q[$];
  bit          slv_nack = 1'b0;
  bit          mon_en = 1'b1;

  int vec = 0;
  int err = 0;
  logic [11:0] want, got;

  function automatic logic [11:0] mk(input logic [1:0] k, input logic [7:0] d, input logic a);
    return {k, 1'b0, a, d};
  endfunction

  // slave model and bus monitor
  bit prev_scl = 1'b1, prev_sda = 1'b1;
  int bitcnt = 0;
  logic [7:0] mon_sh = 8'h00, cur_rd = 8'hFF;
  bit active = 1'b0, addr_phase = 1'b0, rd_mode = 1'b0;
  logic ackb;
  always @(scl_line or sda_line) begin
    if (prev_scl && scl_line && prev_sda && !sda_line) begin
      if (mon_en) obs_q.push_back(mk(K_S, 8'h00, 1'b0));
      active = 1'b1; addr_phase = 1'b1; rd_mode = 1'b0; bitcnt = 0; slv_sda = 1'b1;
    end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
      if (mon_en) obs_q.push_back(mk(K_P, 8'h00, 1'b0));
      active = 1'b0; slv_sda = 1'b1;
    end else if (!prev_scl && scl_line) begin
      if (active) begin
        if (bitcnt < 8) begin
          mon_sh = {mon_sh[6:0], sda_line};
          bitcnt++;
        end else if (bitcnt == 8) begin
          ackb = sda_line;
          if (mon_en) obs_q.push_back(mk(K_B, mon_sh, ackb));
          if (addr_phase) begin
            rd_mode = mon_sh[0] && !ackb;
            addr_phase = 1'b0;
          end else if (rd_mode && ackb) begin
            rd_mode = 1'b0;
          end
          bitcnt = 9;
        end
      end
    end else if (prev_scl && !scl_line) begin
      if (active) begin
        if (bitcnt == 9) bitcnt = 0;
        if (bitcnt == 0 && rd_mode) cur_rd = (slv_rd_q.size() > 0) ? slv_rd_q.pop_front() : 8'hFF;
        if (bitcnt < 8) slv_sda = rd_mode ? cur_rd[7 - bitcnt] : 1'b1;
        else            slv_sda = (rd_mode || slv_nack) ? 1'b1 : 1'b0;
      end
    end
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  // one-clock client request
  task automatic client_req(input bit st, input bit sd, input bit rc, input logic [7:0] d);
    @(negedge clk);
    bus.start = st; bus.send = sd; bus.receive = rc; bus.datasend = d;
    @(negedge clk);
    bus.start = 1'b0; bus.send = 1'b0; bus.receive = 1'b0;
  endtask

  // bounded wait: 0 isReady, 1 sended, 2 received, 3 !sended, 4 ack_error
  task automatic wait_for(input int which, input int budget, output bit ok, output bit saw_snd, output int cycles);
    ok = 1'b0; saw_snd = 1'b0; cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.sended) saw_snd = 1'b1;
      case (which)
        0: if (bus.isReady)   ok = 1'b1;
        1: if (bus.sended)    ok = 1'b1;
        2: if (bus.received)  ok = 1'b1;
        3: if (!bus.sended)   ok = 1'b1;
        4: if (bus.ack_error) ok = 1'b1;
        default: ;
      endcase
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    vec++; if (bus.isReady !== 1'b1) begin err++; $display("FAIL rst isReady: got %b want 1", bus.isReady); end
    vec++; if (bus.sended !== 1'b0) begin err++; $display("FAIL rst sended: got %b want 0", bus.sended); end
    vec++; if (bus.received !== 1'b0) begin err++; $display("FAIL rst received: got %b want 0", bus.received); end
    vec++; if (bus.datareceive !== 8'h00) begin err++; $display("FAIL rst datareceive: got %h want 00", bus.datareceive); end
    vec++; if (bus.ack_error !== 1'b0) begin err++; $display("FAIL rst ack_error: got %b want 0", bus.ack_error); end
    vec++; if (bus.scl_o !== 1'b1) begin err++; $display("FAIL rst scl_o: got %b want 1", bus.scl_o); end
    vec++; if (bus.sda_oe !== 1'b0) begin err++; $display("FAIL rst sda_oe: got %b want 0", bus.sda_oe); end
  endtask

  task automatic test_write_read_id();
    bit ok, saw; int cyc;
    slv_rd_q.push_back(8'h55); slv_rd_q.push_back(8'hA5);
    exp_q.push_back(mk(K_S, 8'h00, 1'b0)); exp_q.push_back(mk(K_B, 8'hEE, 1'b0));
    client_req(1'b1, 1'b0, 1'b0, 8'hEE);
    wait_for(1, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL wrid sended after EE: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(K_B, 8'hD0, 1'b0));
    client_req(1'b0, 1'b1, 1'b0, 8'hD0);
    wait_for(1, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL wrid sended after D0: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(K_S, 8'h00, 1'b0)); exp_q.push_back(mk(K_B, 8'hEF, 1'b0));
    client_req(1'b1, 1'b1, 1'b0, 8'hEF);
    wait_for(2, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL wrid received 1st: got %b want 1", ok); end
    vec++; if (bus.datareceive !== 8'h55) begin err++; $display("FAIL wrid datareceive: got %h want 55", bus.datareceive); end
    repeat (2) @(negedge clk);
    vec++; if (bus.datareceive !== 8'h55) begin err++; $display("FAIL wrid datareceive hold: got %h want 55", bus.datareceive); end
    vec++; if (bus.received !== 1'b1) begin err++; $display("FAIL wrid received hold: got %b want 1", bus.received); end
    exp_q.push_back(mk(K_B, 8'h55, 1'b0));
    client_req(1'b0, 1'b0, 1'b1, 8'h00);
    exp_q.push_back(mk(K_B, 8'hA5, 1'b1)); exp_q.push_back(mk(K_P, 8'h00, 1'b0));
    wait_for(2, 2000, ok, saw, cyc);
    vec++; if (bus.datareceive !== 8'hA5) begin err++; $display("FAIL wrid datareceive 2nd: got %h want a5", bus.datareceive); end
    wait_for(0, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL wrid isReady: got %b want 1", ok); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'h000;
      vec++; if (got !== want) begin err++; $display("FAIL wrid bus token: got %03h want %03h", got, want); end
    end
    vec++; if (obs_q.size() != 0) begin err++; $display("FAIL wrid extra tokens: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_addr_nack();
    bit ok, saw1, saw2; int cyc;
    slv_nack = 1'b1;
    exp_q.push_back(mk(K_S, 8'h00, 1'b0)); exp_q.push_back(mk(K_B, 8'hEE, 1'b1)); exp_q.push_back(mk(K_P, 8'h00, 1'b0));
    client_req(1'b1, 1'b0, 1'b0, 8'hEE);
    wait_for(4, 2000, ok, saw1, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL nack ack_error: got %b want 1", ok); end
    wait_for(0, 4 * CLK_DIV + 4, ok, saw2, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL nack isReady within bit: got %b want 1", ok); end
    vec++; if ((saw1 | saw2) !== 1'b0) begin err++; $display("FAIL nack sended rose: got %b want 0", saw1 | saw2); end
    vec++; if (bus.ack_error !== 1'b1) begin err++; $display("FAIL nack ack_error sticky: got %b want 1", bus.ack_error); end
    slv_nack = 1'b0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'h000;
      vec++; if (got !== want) begin err++; $display("FAIL nack bus token: got %03h want %03h", got, want); end
    end
    vec++; if (obs_q.size() != 0) begin err++; $display("FAIL nack extra tokens: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_multi_read();
    bit ok, saw; int cyc;
    logic [7:0] rd [4];
    rd[0] = 8'h12; rd[1] = 8'h34; rd[2] = 8'h56; rd[3] = 8'h78;
    for (int i = 0; i < 4; i++) slv_rd_q.push_back(rd[i]);
    exp_q.push_back(mk(K_S, 8'h00, 1'b0)); exp_q.push_back(mk(K_B, 8'hA1, 1'b0));
    client_req(1'b1, 1'b0, 1'b0, 8'hA1);
    vec++; if (bus.ack_error !== 1'b0) begin err++; $display("FAIL mrd ack_error cleared: got %b want 0", bus.ack_error); end
    for (int i = 0; i < 4; i++) begin
      wait_for(2, 2000, ok, saw, cyc);
      vec++; if (ok !== 1'b1) begin err++; $display("FAIL mrd received %0d: got %b want 1", i, ok); end
      vec++; if (bus.datareceive !== rd[i]) begin err++; $display("FAIL mrd datareceive %0d: got %h want %h", i, bus.datareceive, rd[i]); end
      if (i < 3) begin
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(K_B, rd[i], 1'b0));
        client_req(1'b0, 1'b0, 1'b1, 8'h00);
      end else begin
        exp_q.push_back(mk(K_B, rd[i], 1'b1)); exp_q.push_back(mk(K_P, 8'h00, 1'b0));
      end
    end
    wait_for(0, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL mrd isReady: got %b want 1", ok); end
    vec++; if (bus.datareceive !== 8'h78) begin err++; $display("FAIL mrd last datareceive: got %h want 78", bus.datareceive); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'h000;
      vec++; if (got !== want) begin err++; $display("FAIL mrd bus token: got %03h want %03h", got, want); end
    end
    vec++; if (obs_q.size() != 0) begin err++; $display("FAIL mrd extra tokens: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_wr_timeout();
    bit ok, saw; int cyc;
    exp_q.push_back(mk(K_S, 8'h00, 1'b0)); exp_q.push_back(mk(K_B, 8'hEE, 1'b0));
    client_req(1'b1, 1'b0, 1'b0, 8'hEE);
    wait_for(1, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL wto sended: got %b want 1", ok); end
    exp_q.push_back(mk(K_P, 8'h00, 1'b0));
    wait_for(3, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1 || cyc < IDLE_TO * CLK_DIV - 1 || cyc > IDLE_TO * CLK_DIV + 1)
      begin err++; $display("FAIL wto sended fall cycles: got %0d want %0d", cyc, IDLE_TO * CLK_DIV); end
    wait_for(0, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL wto isReady: got %b want 1", ok); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'h000;
      vec++; if (got !== want) begin err++; $display("FAIL wto bus token: got %03h want %03h", got, want); end
    end
    vec++; if (obs_q.size() != 0) begin err++; $display("FAIL wto extra tokens: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_send_receive();
    bit ok, saw; int cyc;
    exp_q.push_back(mk(K_S, 8'h00, 1'b0)); exp_q.push_back(mk(K_B, 8'hEE, 1'b0));
    client_req(1'b1, 1'b0, 1'b0, 8'hEE);
    wait_for(1, 2000, ok, saw, cyc);
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(K_B, 8'h3C, 1'b0));
    client_req(1'b0, 1'b1, 1'b1, 8'h3C);
    wait_for(1, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL sr sended after write: got %b want 1", ok); end
    vec++; if (bus.received !== 1'b0) begin err++; $display("FAIL sr received: got %b want 0", bus.received); end
    exp_q.push_back(mk(K_P, 8'h00, 1'b0));
    wait_for(0, 2000, ok, saw, cyc);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'h000;
      vec++; if (got !== want) begin err++; $display("FAIL sr bus token: got %03h want %03h", got, want); end
    end
    vec++; if (obs_q.size() != 0) begin err++; $display("FAIL sr extra tokens: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok, saw; int cyc;
    client_req(1'b1, 1'b0, 1'b0, 8'hEE);
    repeat (88) @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    vec++; if (bus.scl_o !== 1'b1) begin err++; $display("FAIL rmid scl_o: got %b want 1", bus.scl_o); end
    vec++; if (bus.sda_oe !== 1'b0) begin err++; $display("FAIL rmid sda_oe: got %b want 0", bus.sda_oe); end
    vec++; if (bus.isReady !== 1'b1) begin err++; $display("FAIL rmid isReady: got %b want 1", bus.isReady); end
    vec++; if (bus.sended !== 1'b0) begin err++; $display("FAIL rmid sended: got %b want 0", bus.sended); end
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    exp_q.push_back(mk(K_S, 8'h00, 1'b0)); exp_q.push_back(mk(K_B, 8'hEE, 1'b0));
    client_req(1'b1, 1'b0, 1'b0, 8'hEE);
    wait_for(1, 2000, ok, saw, cyc);
    vec++; if (ok !== 1'b1) begin err++; $display("FAIL rmid sended after restart: got %b want 1", ok); end
    exp_q.push_back(mk(K_P, 8'h00, 1'b0));
    wait_for(0, 2000, ok, saw, cyc);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'h000;
      vec++; if (got !== want) begin err++; $display("FAIL rmid bus token: got %03h want %03h", got, want); end
    end
    vec++; if (obs_q.size() != 0) begin err++; $display("FAIL rmid extra tokens: got %0d want 0", obs_q.size()); end
  endtask

  initial begin
    bus.start = 1'b0; bus.send = 1'b0; bus.receive = 1'b0; bus.datasend = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_write_read_id();
    test_addr_nack();
    test_multi_read();
    test_wr_timeout();
    test_send_receive();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Byte-level I2C master engine serving the client side of the sensor controllers (start/send/receive/datasend in; isReady/sended/received/datareceive out).
- Generates START, repeated START, STOP, address/data bytes, ACK/NACK on open-drain SCL/SDA.
- Holds SCL low between bytes until the client requests the next byte.

Parameters:
CLK_DIV, 125, clk cycles per SCL quarter-period (≥2); 50 MHz clk gives 100 kHz SCL.
IDLE_TIMEOUT, 64, quarter-periods to wait at a byte boundary before auto NACK/STOP.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level, high = precede the next byte with START (repeated START if bus is active)
send  in  1  pulse, next write byte is on datasend
receive  in  1  pulse, ACK the held read byte and read another
datasend  in  8  byte to transmit; in a START byte, bit0 = R/W (1 = read)
isReady  out  1  engine idle, bus released
sended  out  1  high = byte transmitted and ACKed, awaiting client request
datareceive  out  8  last byte read, MSB first
received  out  1  high = datareceive valid, awaiting client decision
scl_o  out  1  0 = drive SCL low, 1 = release
sda_oe  out  1  1 = drive SDA low
sda_i  in  1  sampled SDA
ack_error  out  1  sticky; slave NACKed a written byte; cleared by next START

Behaviour:
- Reset (async, any state): state IDLE, isReady=1, sended=0, received=0, datareceive=0x00, ack_error=0, scl_o=1, sda_oe=0, all counters 0. Mid-transfer reset releases the bus at once; no STOP is generated.
- A quarter tick strobes every CLK_DIV clks. All bus transitions happen on ticks. A bit is 4 quarters:
  - q0: set SDA with SCL low.
  - q1: raise SCL.
  - q2: sample sda_i.
  - q3: lower SCL.
- States: IDLE, START_GEN, WR_BIT, WR_ACK, WR_WAIT, RD_BIT, RD_WAIT, RD_ACK, STOP_GEN.
- IDLE → START_GEN when start=1 (level check on clk):
  - latch datasend and its bit0 as rw;
  - isReady←0 on the same edge; clear ack_error.
  - start=0 with send in IDLE is ignored.
- START_GEN: release SDA and SCL, then SDA low one quarter, then SCL low one quarter → WR_BIT.
- WR_BIT: 8 bits, MSB first → WR_ACK.
  - WR_ACK samples sda_i at q2.
  - sda_i=1 (NACK): ack_error←1 → STOP_GEN.
  - ACK, latched rw=1 (read address) → RD_BIT directly; sended not raised.
  - ACK otherwise: sended←1 → WR_WAIT.
- WR_WAIT (SCL held low):
  - send=1 with start=0: latch datasend, sended←0 → WR_BIT.
  - send=1 with start=1: latch datasend and rw, sended←0 → START_GEN (repeated START).
  - receive=1: sended←0 → RD_BIT.
  - No request for IDLE_TIMEOUT ticks: sended←0 → STOP_GEN.
  - send and receive in the same cycle: send wins.
- RD_BIT: sda_oe=0; shift sda_i in at q2 for 8 bits.
  - Then datareceive←shifted byte, received←1 on the same clk → RD_WAIT.
  - datareceive is stable while received=1.
- RD_WAIT (SCL held low):
  - receive=1: received←0, drive ACK (sda_oe=1) one bit → RD_BIT.
  - Timeout: received←0, NACK (sda_oe=0) one bit → STOP_GEN.
  - send or start pulses are ignored in RD_WAIT.
- STOP_GEN: SDA low, SCL high, then SDA released one quarter later, plus one quarter bus-free → IDLE, isReady←1.
- sended and received are levels with clean single rise/fall per byte. The client edge-detects both edges, so each must stay high ≥2 clks. This is guaranteed because the client request arrives ≥2 clks after the rise.
- Start/send/receive are sampled only in the states listed; pulses in other states are dropped.

Test Plan:
- Write-then-read ID: start=1, datasend=0xEE, slave ACKs all, send 0xD0, then start=1+send 0xEF, one receive, slave returns 0x55 → bus shows S EE A D0 A Sr EF A 55 A, then the next byte; timeout gives NACK P; datareceive=0x55 while received=1.
- Address NACK: start with 0xEE, sda_i held 1 at ACK → ack_error=1, STOP, isReady=1 after 1 bit-time; sended never rises.
- Multi-byte read: 3 receive pulses, slave data 0x12,0x34,0x56,0x78 → received rises 4 times, ACK ×3 then NACK, STOP; last datareceive=0x78.
- Idle timeout in WR_WAIT: no send for 64 ticks → sended falls, STOP emitted, isReady=1.
- Reset mid-byte: assert reset during bit 4 of WR_BIT → same-cycle scl_o=1, sda_oe=0, isReady=1, sended=0; a new start works normally.
- Simultaneous send+receive in WR_WAIT → treated as send (a write byte follows).
